// File: rtl/traffic_gen_req_sched.sv
// Request scheduler for a traffic generator: issues alternating read/write
// requests in bursts of windowed REQ cycles separated by idle gaps.
module traffic_gen_req_sched #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] n_total_reqs_i,
  input  logic [CNT_W-1:0] t_ck_reqs_i,
  input  logic [CNT_W-1:0] t_ck_idle_i,
  output logic             r_req_valid_o,
  input  logic             r_req_ready_i,
  output logic             w_req_valid_o,
  input  logic             w_req_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cnt_r_reqs_o,
  output logic [CNT_W-1:0] cnt_w_reqs_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_DONE} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] n_total_q;
  logic [CNT_W-1:0] t_reqs_q;
  logic [CNT_W-1:0] t_idle_q;
  logic [CNT_W-1:0] cnt_r_q;
  logic [CNT_W-1:0] cnt_w_q;
  logic [CNT_W-1:0] win_q;
  logic [CNT_W-1:0] gap_q;
  logic             nxt_w_q;
  logic             r_valid_q;
  logic             w_valid_q;
  logic             busy_q;
  logic             done_q;

  logic [CNT_W-1:0] win_end;
  logic [CNT_W-1:0] total_nxt;
  logic             win_last;
  logic             gap_last;
  logic             r_acc;
  logic             w_acc;

  // A zero-length window still gets one REQ cycle; the window counter
  // saturates on its last value so an extended REQ keeps reporting "last".
  assign win_end   = (t_reqs_q == '0) ? '0 : t_reqs_q - CNT_W'(1);
  assign win_last  = (win_q == win_end);
  assign gap_last  = (gap_q == t_idle_q - CNT_W'(1));
  assign r_acc     = r_valid_q & r_req_ready_i;
  assign w_acc     = w_valid_q & w_req_ready_i;
  assign total_nxt = cnt_r_q + cnt_w_q + CNT_W'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      n_total_q <= '0;
      t_reqs_q  <= '0;
      t_idle_q  <= '0;
      cnt_r_q   <= '0;
      cnt_w_q   <= '0;
      win_q     <= '0;
      gap_q     <= '0;
      nxt_w_q   <= 1'b0;
      r_valid_q <= 1'b0;
      w_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (clear_i) begin
      state_q   <= S_IDLE;
      n_total_q <= '0;
      t_reqs_q  <= '0;
      t_idle_q  <= '0;
      cnt_r_q   <= '0;
      cnt_w_q   <= '0;
      win_q     <= '0;
      gap_q     <= '0;
      nxt_w_q   <= 1'b0;
      r_valid_q <= 1'b0;
      w_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            n_total_q <= n_total_reqs_i;
            t_reqs_q  <= t_ck_reqs_i;
            t_idle_q  <= t_ck_idle_i;
            cnt_r_q   <= '0;
            cnt_w_q   <= '0;
            win_q     <= '0;
            gap_q     <= '0;
            nxt_w_q   <= 1'b0;
            busy_q    <= 1'b1;
            if (n_total_reqs_i == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_REQ;
              r_valid_q <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (r_acc || w_acc) begin
            if (r_acc) cnt_r_q <= cnt_r_q + CNT_W'(1);
            else       cnt_w_q <= cnt_w_q + CNT_W'(1);
            nxt_w_q <= ~nxt_w_q;
            if (total_nxt == n_total_q) begin
              state_q   <= S_DONE;
              r_valid_q <= 1'b0;
              w_valid_q <= 1'b0;
              done_q    <= 1'b1;
            end else if (win_last && (t_idle_q != '0)) begin
              state_q   <= S_GAP;
              gap_q     <= '0;
              r_valid_q <= 1'b0;
              w_valid_q <= 1'b0;
            end else begin
              // Either mid-window or back-to-back windows with no gap.
              win_q     <= win_last ? '0 : win_q + CNT_W'(1);
              r_valid_q <= nxt_w_q;
              w_valid_q <= ~nxt_w_q;
            end
          end else if (!win_last) begin
            win_q <= win_q + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (gap_last) begin
            state_q   <= S_REQ;
            win_q     <= '0;
            r_valid_q <= ~nxt_w_q;
            w_valid_q <= nxt_w_q;
          end else begin
            gap_q <= gap_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q   <= S_IDLE;
          r_valid_q <= 1'b0;
          w_valid_q <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign r_req_valid_o = r_valid_q;
  assign w_req_valid_o = w_valid_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign cnt_r_reqs_o  = cnt_r_q;
  assign cnt_w_reqs_o  = cnt_w_q;

endmodule

// File: doc/traffic_gen_req_sched.md
TRAFFIC_GEN_REQ_SCHED -- requirements
Module: traffic_gen_req_sched

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of all count, config and window counters.
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port clear_i  input  1  synchronous clear, active-high.
REQ-005 SHALL have port start_i  input  1  start request, sampled only in IDLE.
REQ-006 SHALL have port n_total_reqs_i  input  CNT_W  total requests to issue (reads plus writes).
REQ-007 SHALL have port t_ck_reqs_i  input  CNT_W  request-window length in cycles.
REQ-008 SHALL have port t_ck_idle_i  input  CNT_W  idle-gap length in cycles.
REQ-009 SHALL have port r_req_valid_o  output  1  read request valid towards the r_reqs source.
REQ-010 SHALL have port r_req_ready_i  input  1  read request accepted.
REQ-011 SHALL have port w_req_valid_o  output  1  write request valid towards the w_reqs sink.
REQ-012 SHALL have port w_req_ready_i  input  1  write request accepted.
REQ-013 SHALL have port busy_o  output  1  high in every state except IDLE.
REQ-014 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-015 SHALL have ports cnt_r_reqs_o and cnt_w_reqs_o  output  CNT_W  accepted read/write counts of the current or last run.

Function
REQ-016 SHALL implement the states IDLE, REQ, GAP and DONE.
REQ-017 SHALL latch all three config inputs on an accepted start; later input changes SHALL have no effect until the next start.
REQ-018 On start in IDLE, SHALL clear both counts and set next type to read.
REQ-019 After a start in IDLE, SHALL go to REQ (or to DONE if n_total_reqs=0); start in other states SHALL be ignored.
REQ-020 In REQ, exactly one valid SHALL be high, selected by next type.
REQ-021 A request SHALL be accepted on the cycle where its valid and ready are both high.
REQ-022 On each accepted request, SHALL increment the matching count and toggle next type (R,W,R,W...).
REQ-023 Valid SHALL stay high and type unchanged until accepted; it SHALL never be withdrawn.
REQ-024 The REQ window SHALL last max(t_ck_reqs,1) cycles, counted from the first REQ cycle.
REQ-025 If the last window cycle has an unaccepted valid, REQ SHALL extend until acceptance; no new request SHALL start after that acceptance.
REQ-026 On window end, SHALL go to GAP for t_ck_idle cycles with both valids low.
REQ-027 If t_ck_idle=0, SHALL skip GAP and open a new REQ window on the next cycle.
REQ-028 Valid output SHALL therefore be continuous across windows when t_ck_idle=0.
REQ-029 When cnt_r+cnt_w reaches n_total_reqs on an acceptance, SHALL go to DONE on the next cycle, regardless of window position.
REQ-030 DONE SHALL last one cycle with done_o=1, then go to IDLE.
REQ-031 Counts SHALL hold their values in IDLE until the next start.
REQ-032 Counters SHALL not wrap: the total never exceeds n_total_reqs, and the window/gap counters are CNT_W wide and compared for equality.
REQ-033 clear_i SHALL have the same effect as reset, synchronously, and SHALL take priority over start_i and handshakes in the same cycle.

Reset
REQ-034 On rst_i assertion, SHALL immediately enter IDLE.
REQ-035 On rst_i assertion, SHALL immediately drive all valids, busy_o and done_o to 0.
REQ-036 On rst_i assertion, SHALL immediately zero all counts, latched config and next type (read).
REQ-037 Reset mid-run SHALL abort without completing an outstanding request and without a done_o pulse.

Verification
REQ-038 n=4, t_reqs=2, t_idle=3, readies held 1, start at cycle 0:
- reads accepted cycles 1 and 6; writes accepted cycles 2 and 7;
- valids low cycles 3-5;
- done_o=1 cycle 8; counts 2/2; busy_o=0 cycle 9.
REQ-039 n=0, start at cycle 0: no valid ever; done_o=1 cycle 1; counts 0/0.
REQ-040 n=4, t_reqs=2, t_idle=2, w_req_ready_i low cycles 2-4: w_req_valid_o held cycles 2-4; accepted cycle 5; GAP cycles 6-7; read at cycle 8.
REQ-041 n=6, t_reqs=1, t_idle=0, readies held 1: valids high cycles 1-6 alternating R/W; done_o cycle 7.
REQ-042 Illegal start or abort mid-run:
- start pulses while busy: ignored;
- n_total_reqs_i changed mid-run: ignored;
- rst_i at cycle 3 of case 038: all outputs 0 immediately, no done_o;
- same with clear_i: all outputs 0 on next edge, no done_o.
